router_rr_arbiter: RTL and testbench
====================================

ROUTER_RR_ARBITER -- requirements
Module: router_rr_arbiter

Interface
REQ-001 SHALL have parameter WIRE_NUM, default 29: flit width in bits, equal to the upstream FIFO word width.
REQ-002 SHALL have parameter NUM_PORTS, default 4: number of input FIFOs arbitrated; legal values 2..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port fifo_dataout, input, NUM_PORTS*WIRE_NUM: head word of each FIFO; port p occupies bits [p*WIRE_NUM +: WIRE_NUM]; valid the same cycle (fall-through).
REQ-006 SHALL have port fifo_empty, input, NUM_PORTS: per-FIFO empty flag.
REQ-007 SHALL have port fifo_read, output, NUM_PORTS: per-FIFO READ strobe, combinational, at most one bit high (one-hot or zero).
REQ-008 SHALL have port out_ready, input, 1: downstream accepts the flit when high with out_valid.
REQ-009 SHALL have port out_valid, output, 1: registered flag; out_data holds a flit.
REQ-010 SHALL have port out_data, output, WIRE_NUM: registered flit.
REQ-011 SHALL have port out_src, output, $clog2(NUM_PORTS): registered index of the source port of out_data.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-013 SHALL define load_en = (state==EMPTY) or (state==HOLD and out_ready).
REQ-014 SHALL, when load_en and any fifo_empty bit is 0, grant the first non-empty port searching from (last_grant+1) mod NUM_PORTS upward with wrap.
REQ-015 SHALL assert fifo_read[g] only in a cycle where load_en is true and port g is granted.
REQ-016 SHALL, at the clock edge ending a grant cycle: latch fifo_dataout of port g into out_data, g into out_src, and g into last_grant; enter or stay in HOLD.
REQ-017 SHALL, when load_en and all FIFOs are empty: assert no fifo_read; in HOLD with out_ready, go to EMPTY; in EMPTY, stay in EMPTY.
REQ-018 SHALL, in HOLD with out_ready=0: keep out_data, out_src and last_grant unchanged and assert no fifo_read.
REQ-019 SHALL have one-cycle latency from a FIFO going non-empty in the EMPTY state to out_valid=1.
REQ-020 SHALL sustain one flit per cycle while out_ready=1 and any FIFO is non-empty (back-to-back transfers with no bubble).
REQ-021 SHALL never assert fifo_read on a port whose fifo_empty is 1.
REQ-022 SHALL compute the round-robin wrap modulo NUM_PORTS, including when NUM_PORTS is not a power of two.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force: state=EMPTY, out_valid=0, out_data=0, out_src=0, last_grant=NUM_PORTS-1 (so port 0 has first priority), and counters=0.
REQ-024 SHALL drive fifo_read=0 during reset; a flit held in HOLD when reset asserts SHALL be discarded.

Configuration
REQ-025 SHALL, when macro ROUTER_ARB_GRANT_CNT_EN is defined: add output grant_cnt, width NUM_PORTS*16, holding one 16-bit counter per port; each counter increments on every fifo_read of its port, wraps 0xFFFF->0, and resets to 0.
REQ-026 SHALL, when ROUTER_ARB_GRANT_CNT_EN is undefined: omit the grant_cnt port and the counter logic; all other behaviour is identical.

Verification
REQ-027 SHALL test: reset, then only port 2 non-empty with head 0x0ABC, out_ready=1 -> fifo_read=4'b0100 in cycle 0; out_valid=1, out_data=0x0ABC, out_src=2 in cycle 1.
REQ-028 SHALL test: all four FIFOs continuously non-empty, out_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles with no bubble.
REQ-029 SHALL test: out_ready held 0 for 5 cycles while out_valid=1 -> out_data and out_src stable and fifo_read=0 for all 5 cycles; on out_ready=1 the next port is granted that same cycle.
REQ-030 SHALL test: ports 1 and 3 non-empty, last_grant=1 -> port 3 granted before port 1 (wrap).
REQ-031 SHALL test: rst_n pulsed low mid-HOLD -> out_valid=0 immediately (asynchronous); after release, port 0 has first priority.
REQ-032 SHALL test, with ROUTER_ARB_GRANT_CNT_EN defined: 3 flits read from port 1 -> grant_cnt[31:16]=3 and all other counters 0.

Source files
------------

// File: rtl/router_rr_arbiter.sv
// rtl/router_rr_arbiter.sv - round-robin arbiter draining NUM_PORTS fall-through FIFOs into one registered flit stage
// Optional per-port grant counters (grant_cnt port) are built when ROUTER_ARB_GRANT_CNT_EN is defined.
module router_rr_arbiter #(
  parameter int WIRE_NUM  = 29,
  parameter int NUM_PORTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*WIRE_NUM-1:0] fifo_dataout,
  input  logic [NUM_PORTS-1:0]          fifo_empty,
  output logic [NUM_PORTS-1:0]          fifo_read,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [WIRE_NUM-1:0]           out_data,
  output logic [$clog2(NUM_PORTS)-1:0]  out_src
`ifdef ROUTER_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]       grant_cnt
`endif
);

  localparam int SRC_W = $clog2(NUM_PORTS);
  localparam int IDX_W = SRC_W + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SRC_W-1:0]    last_grant;
  logic [SRC_W-1:0]    start_idx;
  logic [SRC_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;
  logic                grant_found;
  logic                load_en;
  logic                grant_en;
  logic [WIRE_NUM-1:0] grant_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Search starts one past the last winner; the extra index bit lets the
  // wrap be a single subtract, which stays correct for non-power-of-two counts.
  always_comb begin
    start_idx   = (last_grant == SRC_W'(NUM_PORTS - 1)) ? '0 : last_grant + SRC_W'(1);
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'(start_idx) + IDX_W'(i);
      if (cand >= IDX_W'(NUM_PORTS)) begin
        cand = cand - IDX_W'(NUM_PORTS);
      end
      if (!grant_found && !fifo_empty[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    load_en   = (state == ST_EMPTY) || ((state == ST_HOLD) && out_ready);
    state_nxt = state;
    if (load_en) begin
      state_nxt = grant_found ? ST_HOLD : ST_EMPTY;
    end
  end

  // Read strobe is gated by rst_n so nothing is popped while reset is held.
  always_comb begin
    grant_en  = rst_n && load_en && grant_found;
    fifo_read = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_en && (grant_idx == SRC_W'(p))) begin
        fifo_read[p] = 1'b1;
      end
    end
    out_valid = (state == ST_HOLD);
  end

  always_comb begin
    grant_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == SRC_W'(p)) begin
        grant_data = fifo_dataout[p*WIRE_NUM +: WIRE_NUM];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_W'(NUM_PORTS - 1);
    end else if (grant_en) begin
      out_data   <= grant_data;
      out_src    <= grant_idx;
      last_grant <= grant_idx;
    end
  end

`ifdef ROUTER_ARB_GRANT_CNT_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt[p*16 +: 16] <= '0;
      end else if (fifo_read[p]) begin
        grant_cnt[p*16 +: 16] <= grant_cnt[p*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_rr_arbiter.sv
// tb/tb_router_rr_arbiter.sv - scoreboard bench for router_rr_arbiter with queue-based FIFO and round-robin reference model
module tb_router_rr_arbiter;

  localparam int W  = 29;
  localparam int NP = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP*W-1:0] fifo_dataout;
  logic [NP-1:0] fifo_empty;
  logic [NP-1:0] fifo_read;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
`ifdef ROUTER_ARB_GRANT_CNT_EN
  logic [NP*16-1:0] grant_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] fq [NP][$];
  logic [W-1:0] sb_d[$];
  int           sb_s[$];
  bit           m_valid;
  int           m_last;
  int           cnt [NP];
  int           ready_mode;

  router_rr_arbiter #(.WIRE_NUM(W), .NUM_PORTS(NP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_dataout (fifo_dataout),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_src      (out_src)
`ifdef ROUTER_ARB_GRANT_CNT_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = NP - 1;
    sb_d.delete();
    sb_s.delete();
    for (int p = 0; p < NP; p++) cnt[p] = 0;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p] = (fq[p].size() == 0);
      fifo_dataout[p*W +: W] = (fq[p].size() == 0) ? W'($urandom) : fq[p][0];
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic model_eval();
    logic [NP-1:0] exp_read;
    logic [W-1:0]  tmp;
    int            g;
    int            p;
    bit            load;
    exp_read = '0;
    g = -1;
    chk("out_valid", out_valid, m_valid);
    load = !m_valid || out_ready;
    if (load) begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (g < 0 && fq[p].size() > 0) g = p;
      end
      if (g >= 0) begin
        exp_read[g] = 1'b1;
        sb_d.push_back(fq[g][0]);
        sb_s.push_back(g);
        m_valid = 1'b1;
        m_last  = g;
        cnt[g]  = (cnt[g] + 1) % 65536;
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("fifo_read", fifo_read, exp_read);
    for (int q = 0; q < NP; q++) begin
      if (fifo_read[q] && fq[q].size() > 0) tmp = fq[q].pop_front();
    end
  endtask

  task automatic cycle_body();
    drive_inputs();
    #1;
    model_eval();
  endtask

  task automatic step();
    @(negedge clk);
    cycle_body();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) fq[p].delete();
    model_reset();
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_body();
  endtask

  // Monitor: every accepted output flit must match the oldest predicted flit
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_d.size() == 0) begin
        chk("sb_has_entry", 0, 1);
      end else begin
        chk("mon_data", out_data, sb_d.pop_front());
        chk("mon_src", out_src, sb_s.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit drained;
    ready_mode = 0;
    model_reset();
    fq[1].push_back(29'h1234);
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_fifo_read", fifo_read, 0);
    fq[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle_body();

    // Single source on port 2
    fq[2].push_back(29'h0ABC);
    step();
    chk("p2_read_c0", fifo_read, 4'b0100);
    step();
    chk("p2_valid_c1", out_valid, 1);
    chk("p2_data_c1", out_data, 29'h0ABC);
    chk("p2_src_c1", out_src, 2);

    // All ports busy: strict rotation without bubbles
    do_reset();
    for (int p = 0; p < NP; p++)
      for (int j = 0; j < 3; j++) fq[p].push_back(W'($urandom));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_order", fifo_read, 64'(1) << (k % 4));
      if (k > 0) chk("rr_no_bubble", out_valid, 1);
    end

    // Backpressure: held flit is the most recently predicted one
    ready_mode = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_read", fifo_read, 0);
      chk("bp_data", out_data, sb_d[sb_d.size()-1]);
      chk("bp_src", out_src, sb_s[sb_s.size()-1]);
    end
    ready_mode = 0;
    step();
    chk("bp_release_grant", fifo_read, 4'b0100);

    // Wrap: last grant 1, ports 1 and 3 pending
    do_reset();
    ready_mode = 1;
    fq[1].push_back(29'h111);
    step();
    chk("wrap_first", fifo_read, 4'b0010);
    fq[1].push_back(29'h222);
    fq[3].push_back(29'h333);
    ready_mode = 0;
    step();
    chk("wrap_p3", fifo_read, 4'b1000);
    step();
    chk("wrap_p1", fifo_read, 4'b0010);

    // Asynchronous reset mid-HOLD
    ready_mode = 1;
    fq[0].push_back(29'h444);
    fq[2].push_back(29'h555);
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_read", fifo_read, 0);
    chk("async_rst_data", out_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    cycle_body();
    chk("post_rst_port0", fifo_read, 4'b0001);
    step();
    step();

`ifdef ROUTER_ARB_GRANT_CNT_EN
    do_reset();
    for (int j = 0; j < 3; j++) fq[1].push_back(W'($urandom));
    for (int k = 0; k < 5; k++) step();
    chk("grant_cnt_p1", grant_cnt, 64'(3) << 16);
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) ready_mode = $urandom_range(0, 3) == 0 ? 1 : ($urandom_range(0, 1) == 0 ? 0 : 2);
      for (int p = 0; p < NP; p++)
        if (fq[p].size() < 8 && $urandom_range(0, 3) == 0) fq[p].push_back(W'($urandom));
      step();
    end
    ready_mode = 0;
    drained = 1'b0;
    for (int c = 0; c < 100 && !drained; c++) begin
      step();
      drained = !m_valid;
      for (int p = 0; p < NP; p++) if (fq[p].size() != 0) drained = 1'b0;
    end
    chk("drain_done", drained, 1);
    @(negedge clk);
    #3;
    chk("sb_empty", sb_d.size(), 0);
`ifdef ROUTER_ARB_GRANT_CNT_EN
    for (int p = 0; p < NP; p++) chk("grant_cnt_rand", grant_cnt[p*16 +: 16], cnt[p]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
